// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    localparam int DIV_DIVIDEND_W = 16;
    localparam int DIV_DIVISOR_W  = 8;
    localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, try to subtract the divisor, keep the difference if it is non-negative.
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] trial;

    // The incoming partial remainder is always below the divisor, so its MSB is
    // zero and {rem_i, bit_i} equals the shifted value with one guard bit on top.
    assign shifted = {rem_i[DIVISOR_W-1:0], bit_i};
    assign trial   = {rem_i, bit_i} - {2'b00, divisor_i};

    // A set guard bit means the subtraction went negative: restore.
    assign q_o   = ~trial[DIVISOR_W+1];
    assign rem_o = trial[DIVISOR_W+1] ? shifted : trial[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_SIGNED_EN: two's complement operands, truncating division,
// remainder takes the dividend's sign; sign fix-up happens on RUN -> DONE.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and the
// result outputs stay stable until the out_valid & out_ready edge.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W    = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;     // partial remainder
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  remo_q, remo_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic                  divisor_zero;
    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;
    logic [DIVIDEND_W-1:0] dvd_next;
    logic [DIVIDEND_W-1:0] dvd_cap;
    logic [DIVISOR_W-1:0]  dvs_cap;
    logic [DIVIDEND_W-1:0] quot_fix;
    logic [DIVISOR_W-1:0]  rem_fix;

    assign accept       = in_valid & in_ready;
    assign divisor_zero = (divisor == '0);

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign dvd_next = {dvd_q[DIVIDEND_W-2:0], step_q};

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // The core only ever sees magnitudes; signs are reapplied at the end.
    assign dvd_cap  = dividend[DIVIDEND_W-1] ? ({DIVIDEND_W{1'b0}} - dividend) : dividend;
    assign dvs_cap  = divisor[DIVISOR_W-1] ? ({DIVISOR_W{1'b0}} - divisor) : divisor;
    assign quot_fix = qneg_q ? ({DIVIDEND_W{1'b0}} - dvd_next) : dvd_next;
    assign rem_fix  = rneg_q ? ({DIVISOR_W{1'b0}} - step_rem[DIVISOR_W-1:0])
                             : step_rem[DIVISOR_W-1:0];

    // Result signs are latched together with the operands.
    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            qneg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            rneg_d = dividend[DIVIDEND_W-1];
        end
    end

    // Sign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign dvd_cap  = dividend;
    assign dvs_cap  = divisor;
    assign quot_fix = dvd_next;
    assign rem_fix  = step_rem[DIVISOR_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: divide by zero skips RUN entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = divisor_zero ? DONE : RUN;
            RUN:  if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: capture, iterate, then latch the final result.
    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d = dvd_cap;
                    dvs_d = dvs_cap;
                    rem_d = '0;
                    cnt_d = CNT_LOAD;
                    if (divisor_zero) begin
                        quot_d = '1;
                        remo_d = '0;
                        dbz_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                dvd_d = dvd_next;
                rem_d = step_rem;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    quot_d = quot_fix;
                    remo_d = rem_fix;
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule
